// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding and sizing constants for the instruction-memory boot loader
package imem_pkg;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERROR} state_t;
  localparam int WORD_SIZE_POW = 2;
  localparam int WORD_SIZE = 1 << WORD_SIZE_POW;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles little-endian bytes into words and emits each as a one-cycle registered pulse
module byte_word_packer
  import imem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [7:0]                byte_data,
  input  logic                      byte_en,
  output logic [WORD_SIZE*8-1:0]    word,
  output logic                      word_valid
);
  logic [1:0]                   lane;
  logic [(WORD_SIZE-1)*8-1:0]   asm_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      asm_q      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= '0;
      end else if (byte_en) begin
        lane <= lane + 2'd1;
        if (lane == 2'(WORD_SIZE - 1)) begin
          word       <= {byte_data, asm_q};
          word_valid <= 1'b1;
        end else begin
          asm_q[{lane, 3'b000} +: 8] <= byte_data;
        end
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte image into instruction memory, then releases the core
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH_POW = 10
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  wr_en_out,
  output logic [DATA_WIDTH-1:0] wr_data_out,
  output logic                  core_rst_n_out,
  output logic                  done_out,
  output logic                  error_out
);
  localparam int IW = MEM_DEPTH_POW + 1;
  state_t                   state, nxt;
  logic [7:0]               hdr_lo;
  logic [HDR_BYTES*8-1:0]   hdr;
  logic [IW-1:0]            word_index, n_words;
  logic [WORD_SIZE*8-1:0]   word;
  logic                     acc, restart, last;
  assign acc     = byte_valid_in && byte_ready_out;
  assign restart = (state == DONE || state == ERROR) && start_in;
  assign hdr     = {byte_in, hdr_lo};
  assign last    = (word_index + IW'(1)) == n_words;
  byte_word_packer u_packer (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .clr       (restart),
    .byte_data (byte_in),
    .byte_en   (acc && state == DATA),
    .word      (word),
    .word_valid(wr_en_out)
  );
  assign wr_data_out = DATA_WIDTH'(word);
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= LEN_LO;
    else           state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      LEN_LO:      if (acc) nxt = LEN_HI;
      LEN_HI:      if (acc) nxt = (hdr == '0) ? DONE :
                                  (32'(hdr) > (32'd1 << MEM_DEPTH_POW)) ? ERROR : DATA;
      DATA:        if (wr_en_out && last) nxt = DONE;
      DONE, ERROR: if (start_in) nxt = LEN_LO;
      default:     nxt = LEN_LO;
    endcase
  end
  always_comb begin
    byte_ready_out = state == LEN_LO || state == LEN_HI || state == DATA;
    core_rst_n_out = state == DONE;
    done_out       = state == DONE;
    error_out      = state == ERROR;
    mem_addr_out   = (state == DONE) ? fetch_addr_in : ADDR_WIDTH'(word_index) << WORD_SIZE_POW;
  end
  // word_index holds the address of the pending write and advances once that write has issued
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hdr_lo     <= '0;
      n_words    <= '0;
      word_index <= '0;
    end else begin
      if (state == LEN_LO && acc) hdr_lo <= byte_in;
      if (state == LEN_HI && acc) n_words <= IW'(hdr);
      if (restart)        word_index <= '0;
      else if (wr_en_out) word_index <= word_index + IW'(1);
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed image loads with a write scoreboard checked by an independent monitor
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        start = 1'b0;
  logic [63:0] fetch_addr = '0;
  logic [63:0] mem_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        core_rst_n, done, err;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t q[$];
  int total = 0;
  int bad = 0;

  imem_boot_loader dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .byte_in       (byte_in),
    .byte_valid_in (byte_valid),
    .byte_ready_out(byte_ready),
    .start_in      (start),
    .fetch_addr_in (fetch_addr),
    .mem_addr_out  (mem_addr),
    .wr_en_out     (wr_en),
    .wr_data_out   (wr_data),
    .core_rst_n_out(core_rst_n),
    .done_out      (done),
    .error_out     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, e);
    end
  endtask

  task automatic expect_wr(input logic [63:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    q.push_back(w);
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready), 64'd1);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_addr"}, mem_addr, 64'd0);
    chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (q.size() == 0) begin
        chk("extra_strobe", 64'(wr_en), 64'd0);
      end else begin
        wr_t w;
        w = q.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", 64'(wr_data), 64'(w.d));
      end
    end
  end

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    expect_wr(64'h0, 32'h00100513);
    expect_wr(64'h4, 32'h00200593);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h05); send(8'h10); send(8'h00);
    send(8'h93); send(8'h05); send(8'h20); send(8'h00);
    chk("two_done_early", 64'(done), 64'd0);
    idle(1);
    chk("two_done", 64'(done), 64'd1);
    chk("two_core_rst_n", 64'(core_rst_n), 64'd1);
    chk("two_ready", 64'(byte_ready), 64'd0);
    chk("two_sb_empty", 64'(q.size()), 64'd0);

    fetch_addr = 64'h8;
    #1 chk("fetch_mux", mem_addr, 64'h8);
    pulse_start();
    chk("restart_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("restart_addr", mem_addr, 64'h0);
    chk("restart_ready", 64'(byte_ready), 64'd1);

    send(8'h00); send(8'h00);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_core_rst_n", 64'(core_rst_n), 64'd1);
    pulse_start();

    send(8'h01); send(8'h04);
    chk("big_err", 64'(err), 64'd1);
    chk("big_ready", 64'(byte_ready), 64'd0);
    chk("big_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("big_done", 64'(done), 64'd0);
    byte_valid = 1'b1;
    idle(3);
    byte_valid = 1'b0;
    chk("big_hold", 64'(err), 64'd1);
    pulse_start();
    chk("big_restart_err", 64'(err), 64'd0);
    chk("big_restart_ready", 64'(byte_ready), 64'd1);

    expect_wr(64'h0, 32'hDEADBEEF);
    send(8'h01); idle(1); send(8'h00); idle(1);
    send(8'hEF); idle(1); send(8'hBE); idle(1);
    send(8'hAD); idle(1); send(8'hDE);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    chk("gap_done", 64'(done), 64'd1);
    idle(2);
    chk("gap_sb_empty", 64'(q.size()), 64'd0);
    pulse_start();

    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    expect_wr(64'h0, 32'h04030201);
    expect_wr(64'h4, 32'h08070605);
    send(8'h02); send(8'h00);
    for (int i = 1; i <= 8; i++) send(8'(i));
    idle(1);
    chk("reload_done", 64'(done), 64'd1);
    chk("reload_sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
